motor_move_scheduler: RTL
=========================

Name: motor_move_scheduler

Overview:
- Sequences the six-axis stepper drive that sits behind the button/coordinate front end.
- After reset it homes each motor in turn against its Stop switch, then accepts absolute-target move commands per motor.
- Moves are granted round-robin to one shared step-pulse timer and emitted on PU/DR/MF.
- Only one motor steps at a time. The front end only produces {motor, target} and never touches PU/DR/MF directly.

Parameters:
- N_MOTOR, 6: number of axes; widths of Stop/PU/MF/DR.
- POS_W, 10: position/target register width.
- MAX_POS, 999: largest legal target (3 decimal digits).
- PULSE_DIV, 50: sysclk cycles per PU half-period (high time = low time = PULSE_DIV).
- HOME_DIR, 0: DR level that drives an axis toward its Stop switch.
- HOME_MAX_STEPS, 1023: step limit per axis; used only with HOME_TIMEOUT_EN.

Ports:
- sysclk, in, 1: system clock.
- rst, in, 1: asynchronous active-low reset.
- Stop, in, N_MOTOR: limit/home switches, asynchronous, active-high.
- cmd_valid, in, 1: command strobe.
- cmd_ready, out, 1: command accepted this cycle when cmd_valid && cmd_ready.
- cmd_motor, in, 3: target axis, 0..N_MOTOR-1.
- cmd_target, in, POS_W: absolute target position.
- cmd_err, out, 1: one-cycle pulse when an offered command is rejected.
- PU, out, N_MOTOR: step pulses.
- DR, out, N_MOTOR: direction (1 = increasing position).
- MF, out, N_MOTOR: driver enable (1 = energised).
- homed, out, 1: all axes calibrated.
- busy, out, 1: homing or a move is in progress.
- cur_motor, out, 3: axis currently owned by the pulse timer.
- home_err, out, N_MOTOR: homing timeout flags (tied 0 when the feature is off).

Behaviour:
- Reset (rst=0, asynchronous):
  - PU=0, DR=0, MF=0, cmd_ready=0, cmd_err=0, homed=0, busy=0, cur_motor=0, home_err=0.
  - All pos[i]=0, pending[i]=0; state=HOME_SEL, i=0.
  - A reset asserted mid-move or mid-homing aborts immediately. Homing restarts from axis 0 after release.
- Stop is double-flop synchronised. Every "Stop high" below refers to the synchronised value, which lags the pin by 2 cycles.
- States:
  - HOME_SEL: MF[i]=1, DR[i]=HOME_DIR, busy=1. If Stop[i] is high → HOME_ZERO with no pulses; else → HOME_RUN.
  - HOME_RUN: emit steps on PU[i]. Stop[i] is checked at the end of every low half-period. When it is high → HOME_ZERO.
  - HOME_ZERO: pos[i]=0, MF[i]=0. If i=N_MOTOR-1 → IDLE and set homed=1; else i+1 → HOME_SEL.
  - IDLE: busy=0. If any pending[j] is set, grant round-robin starting at (last_granted+1) mod N_MOTOR → MOVE_SETUP.
  - MOVE_SETUP (1 cycle): cur_motor=j, MF[j]=1, DR[j]=(tgt[j]>pos[j]), clear pending[j]. If tgt[j]==pos[j] → IDLE with no pulses; else → MOVE_RUN.
  - MOVE_RUN: each step is PU[j] high for PULSE_DIV cycles, then low for PULSE_DIV cycles. pos[j] changes by ±1 on the PU falling edge. When pos[j]==tgt[j] at the end of a low phase → MOVE_DONE.
  - MOVE_DONE (1 cycle): MF[j]=0, last_granted=j → IDLE.
- Commands:
  - cmd_ready = homed, independent of busy.
  - An accepted command writes tgt[cmd_motor] and sets pending[cmd_motor]; a later command to the same axis overwrites the earlier one.
  - A command to the axis currently moving is stored as pending. The move in progress keeps its latched target; the new target is served on a later grant.
  - Reject with cmd_err=1 and no state change when cmd_motor ≥ N_MOTOR or cmd_target > MAX_POS. cmd_valid while homed=0 is ignored, with no cmd_err.
- Limit hit during a move: if DR[j]==HOME_DIR and Stop[j] goes high, the move aborts at the end of the current step. pos[j]=0 → MOVE_DONE. A pending target for j is kept.
- Only one PU bit may be high at any time. DR/MF are stable for at least PULSE_DIV cycles before the first PU rise.

Optional Feature:
- HOME_TIMEOUT_EN defined:
  - HOME_RUN counts steps.
  - Reaching HOME_MAX_STEPS without Stop sets home_err[i]=1, pos[i]=0, and moves on to the next axis.
  - homed still rises after the last axis.
  - Commands to an axis with home_err set are rejected with cmd_err.
- HOME_TIMEOUT_EN undefined: homing waits on Stop indefinitely; home_err is constant 0.

Test Plan (PULSE_DIV=4):
- Homing: hold Stop=0, then pulse Stop[0]..Stop[5] in sequence → each axis emits PU only while selected, DR=HOME_DIR. homed=1 after Stop[5]; all pos=0.
- Move up: cmd {5, 11} → DR[5]=1, exactly 11 PU[5] pulses each 8 cycles apart; busy falls; MF[5]=0. Then cmd {5, 8} → DR[5]=0, exactly 3 pulses.
- Arbitration: while axis 5 moves, issue cmd {1, 11} then {0, 2} → after axis 5 completes, axis 0 is served before axis 1 (round robin from 5). No overlapping PU bits.
- Rejects: cmd {6, 0} and cmd {2, 1000} → cmd_err pulses once each with no pulses emitted. Cmd {2, 0} with pos[2]=0 → no pulses, no cmd_err.
- Limit abort: axis 3 at 5, cmd {3, 0}, force Stop[3]=1 after 2 steps → move ends, pos[3]=0, busy=0.
- Reset mid-move: drop rst during MOVE_RUN → PU/MF/DR go to 0 in the same cycle, homed=0. After release, homing restarts at axis 0.

Source files
------------

// File: rtl/motor_move_scheduler.sv
// Six-axis stepper sequencer: homes each axis against its Stop switch, then
// serves absolute-target moves round-robin on one shared step-pulse timer.
// Optional macro HOME_TIMEOUT_EN bounds homing by HOME_MAX_STEPS and raises home_err.
module motor_move_scheduler #(
  parameter int unsigned N_MOTOR   = 6,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned MAX_POS   = 999,
  parameter int unsigned PULSE_DIV = 50,
  parameter bit          HOME_DIR  = 1'b0
`ifdef HOME_TIMEOUT_EN
  , parameter int unsigned HOME_MAX_STEPS = 1023
`endif
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [N_MOTOR-1:0] Stop,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_motor,
  input  logic [POS_W-1:0]   cmd_target,
  output logic               cmd_err,
  output logic [N_MOTOR-1:0] PU,
  output logic [N_MOTOR-1:0] DR,
  output logic [N_MOTOR-1:0] MF,
  output logic               homed,
  output logic               busy,
  output logic [2:0]         cur_motor,
  output logic [N_MOTOR-1:0] home_err
);

  localparam int unsigned MW = 3;
  localparam int unsigned CW = $clog2(PULSE_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_DIV - 1);

  typedef enum logic [2:0] {
    HOME_SEL, HOME_RUN, HOME_ZERO, IDLE, MOVE_SETUP, MOVE_RUN, MOVE_DONE
  } state_t;

  state_t             state;
  logic [MW-1:0]      axis;
  logic [MW-1:0]      last_granted;
  logic [POS_W-1:0]   pos [N_MOTOR];
  logic [POS_W-1:0]   tgt [N_MOTOR];
  logic [N_MOTOR-1:0] pending;
  logic [POS_W-1:0]   mv_tgt;
  logic [CW-1:0]      cnt;
  logic               ph_high;
  logic [N_MOTOR-1:0] stop_m;
  logic [N_MOTOR-1:0] stop_s;
  logic               cmd_bad;
  logic               cmd_acc;
  logic               gnt_vld;
  logic [MW-1:0]      gnt_idx;
  logic [MW-1:0]      cand;
  logic               ph_end;

`ifdef HOME_TIMEOUT_EN
  localparam int unsigned HW = $clog2(HOME_MAX_STEPS + 1);
  logic [HW-1:0] hsteps;
`else
  assign home_err = '0;
`endif

  assign cmd_ready = homed;
  assign ph_end    = (cnt == CNT_LAST);

  // Command legality: axis in range and target within the 3-digit window.
  always_comb begin
    cmd_bad = (cmd_motor >= MW'(N_MOTOR)) || (cmd_target > POS_W'(MAX_POS));
`ifdef HOME_TIMEOUT_EN
    if (!cmd_bad && home_err[cmd_motor]) cmd_bad = 1'b1;
`endif
    cmd_acc = cmd_valid && homed && !cmd_bad;
  end

  // Round-robin search starting one past the last axis that completed a move.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_MOTOR; k++) begin
      cand = MW'((32'(last_granted) + k) % N_MOTOR);
      if (!gnt_vld && pending[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state        <= HOME_SEL;
      axis         <= '0;
      last_granted <= MW'(N_MOTOR - 1);
      pending      <= '0;
      mv_tgt       <= '0;
      cnt          <= '0;
      ph_high      <= 1'b0;
      stop_m       <= '0;
      stop_s       <= '0;
      PU           <= '0;
      DR           <= '0;
      MF           <= '0;
      cmd_err      <= 1'b0;
      homed        <= 1'b0;
      busy         <= 1'b0;
      cur_motor    <= '0;
      for (int unsigned k = 0; k < N_MOTOR; k++) begin
        pos[k] <= '0;
        tgt[k] <= '0;
      end
`ifdef HOME_TIMEOUT_EN
      hsteps   <= '0;
      home_err <= '0;
`endif
    end else begin
      stop_m  <= Stop;
      stop_s  <= stop_m;
      cmd_err <= cmd_valid && homed && cmd_bad;

      case (state)
        HOME_SEL: begin
          MF[axis]  <= 1'b1;
          DR[axis]  <= HOME_DIR;
          busy      <= 1'b1;
          cur_motor <= axis;
          cnt       <= '0;
          ph_high   <= 1'b0;
`ifdef HOME_TIMEOUT_EN
          hsteps    <= '0;
`endif
          state     <= stop_s[axis] ? HOME_ZERO : HOME_RUN;
        end

        HOME_RUN: begin
          if (!ph_end) begin
            cnt <= cnt + CW'(1);
          end else if (ph_high) begin
            cnt      <= '0;
            ph_high  <= 1'b0;
            PU[axis] <= 1'b0;
`ifdef HOME_TIMEOUT_EN
            hsteps   <= hsteps + HW'(1);
`endif
          end else begin
            cnt <= '0;
            if (stop_s[axis]) begin
              state <= HOME_ZERO;
`ifdef HOME_TIMEOUT_EN
            end else if (hsteps == HW'(HOME_MAX_STEPS)) begin
              home_err[axis] <= 1'b1;
              state          <= HOME_ZERO;
`endif
            end else begin
              PU[axis] <= 1'b1;
              ph_high  <= 1'b1;
            end
          end
        end

        HOME_ZERO: begin
          pos[axis] <= '0;
          MF[axis]  <= 1'b0;
          if (axis == MW'(N_MOTOR - 1)) begin
            homed <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            axis  <= axis + MW'(1);
            state <= HOME_SEL;
          end
        end

        IDLE: begin
          busy <= gnt_vld;
          if (gnt_vld) begin
            axis  <= gnt_idx;
            state <= MOVE_SETUP;
          end
        end

        // Target is latched here so later commands to this axis wait for a new grant.
        MOVE_SETUP: begin
          cur_motor     <= axis;
          MF[axis]      <= (tgt[axis] != pos[axis]);
          DR[axis]      <= (tgt[axis] > pos[axis]);
          pending[axis] <= 1'b0;
          mv_tgt        <= tgt[axis];
          cnt           <= '0;
          ph_high       <= 1'b0;
          if (tgt[axis] == pos[axis]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= MOVE_RUN;
          end
        end

        MOVE_RUN: begin
          if (!ph_end) begin
            cnt <= cnt + CW'(1);
          end else if (ph_high) begin
            cnt       <= '0;
            ph_high   <= 1'b0;
            PU[axis]  <= 1'b0;
            pos[axis] <= DR[axis] ? pos[axis] + POS_W'(1) : pos[axis] - POS_W'(1);
          end else begin
            cnt <= '0;
            if (DR[axis] == HOME_DIR && stop_s[axis]) begin
              pos[axis] <= '0;
              state     <= MOVE_DONE;
            end else if (pos[axis] == mv_tgt) begin
              state <= MOVE_DONE;
            end else begin
              PU[axis] <= 1'b1;
              ph_high  <= 1'b1;
            end
          end
        end

        MOVE_DONE: begin
          MF[axis]     <= 1'b0;
          last_granted <= axis;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: state <= HOME_SEL;
      endcase

      // Accepted commands win over the pending clear in MOVE_SETUP.
      if (cmd_acc) begin
        tgt[cmd_motor]     <= cmd_target;
        pending[cmd_motor] <= 1'b1;
      end
    end
  end

endmodule
